// File: rtl/rom_msg_sequencer.sv
// ROM message sequencer: walks a combinational character ROM from address 0 and
// streams each byte to a valid/ready character sink. A message ends at MSG_LEN
// characters or, optionally, at the first NUL byte. It supports an optional
// inter-character gap and auto-repeat.
module rom_msg_sequencer #(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned MSG_LEN     = 8,
  parameter int unsigned GAP_CYCLES  = 0,
  parameter int unsigned STOP_ON_NUL = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              repeat_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   char_count
);

  // Gap counter only has to hold GAP_CYCLES-1.
  localparam int unsigned   GapW      = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GapW-1:0] GapLoad = GapW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
  localparam logic [ADDR_W:0] LastCount = (ADDR_W + 1)'(MSG_LEN);

  typedef enum logic [2:0] {StIdle, StFetch, StSend, StGap, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [GapW-1:0]     gap_q, gap_d;
  logic                handshake;

  assign handshake = (state_q == StSend) && valid_q && tx_ready;

  // Next-state logic; abort overrides every state but still credits an accepted character.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = valid_q;
    count_d = count_q;
    gap_d   = gap_q;
    if (abort) begin
      state_d = StIdle;
      valid_d = 1'b0;
      if (handshake) begin
        count_d = count_q + (ADDR_W + 1)'(1);
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            addr_d  = '0;
            count_d = '0;
            state_d = StFetch;
          end
        end
        StFetch: begin
          if ((STOP_ON_NUL != 0) && (rom_data == '0)) begin
            state_d = StDone;
          end else begin
            data_d  = rom_data;
            valid_d = 1'b1;
            state_d = StSend;
          end
        end
        StSend: begin
          if (tx_ready) begin
            valid_d = 1'b0;
            count_d = count_q + (ADDR_W + 1)'(1);
            if (count_d == LastCount) begin
              // Last character: address is left in place so it never wraps.
              state_d = StDone;
            end else begin
              addr_d = addr_q + ADDR_W'(1);
              if (GAP_CYCLES > 0) begin
                gap_d   = GapLoad;
                state_d = StGap;
              end else begin
                state_d = StFetch;
              end
            end
          end
        end
        StGap: begin
          if (gap_q == '0) begin
            state_d = StFetch;
          end else begin
            gap_d = gap_q - GapW'(1);
          end
        end
        StDone: begin
          if (repeat_en) begin
            addr_d  = '0;
            count_d = '0;
            state_d = StFetch;
          end else begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      count_q <= count_d;
      gap_q   <= gap_d;
    end
  end

  assign rom_addr   = addr_q;
  assign tx_data    = data_q;
  assign tx_valid   = valid_q;
  assign char_count = count_q;
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);

endmodule
